// File: rtl/ws2822_addr_programmer.sv
// WS2822 address programmer: power-cycles the strip, then holds ADDRESS low while
// one break/MAB/4-byte frame carrying the target start channel is sent on DATA.
module ws2822_addr_programmer #(
    parameter int CLKS_PER_BIT     = 96,
    parameter int POWER_OFF_CYCLES = 2400000,
    parameter int SETTLE_CYCLES    = 1200000,
    parameter int BREAK_BITS       = 22,
    parameter int MAB_BITS         = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [9:0] i_address,
    input  logic       i_start_strobe,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_error,
    output logic       o_power_en,
    output logic       o_data_pin,
    output logic       o_address_pin
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [23:0] PWR_LAST = 24'(POWER_OFF_CYCLES - 1);
    localparam logic [23:0] SET_LAST = 24'(SETTLE_CYCLES - 1);
    localparam logic [23:0] BRK_LAST = 24'(BREAK_BITS * CLKS_PER_BIT - 1);
    localparam logic [23:0] MAB_LAST = 24'(MAB_BITS * CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE, PWR_OFF, SETTLE, ADDR_SETUP, BREAK, MAB, BYTE, RELEASE
    } state_t;

    state_t        state, state_n;
    logic [23:0]   phase_cnt, phase_n;
    logic [BW-1:0] bit_cnt, bit_cnt_n;
    logic [3:0]    bit_idx, bit_idx_n;
    logic [1:0]    byte_idx, byte_idx_n;
    logic [9:0]    addr_q, addr_n;
    logic          done_q, done_n, error_n;
    logic          busy_c, power_c, data_c, apin_c;
    logic [7:0]    byte_sel;
    logic          frame_bit, bit_end, addr_ok;

    assign bit_end = (bit_cnt == BIT_LAST);
    assign addr_ok = (i_address >= 10'd1) && (i_address <= 10'd512);

    always_comb begin
        case (byte_idx)
            2'd0:    byte_sel = 8'hA0;
            2'd1:    byte_sel = addr_q[7:0];
            2'd2:    byte_sel = {6'b111100, addr_q[9:8]};
            default: byte_sel = addr_q[7:0] ^ {6'b111100, addr_q[9:8]};
        endcase
    end

    // 8N2 framing: index 0 is the start bit, 1..8 data LSB first, 9..10 stop bits
    always_comb begin
        frame_bit = 1'b1;
        if (bit_idx == 4'd0)
            frame_bit = 1'b0;
        else if (bit_idx <= 4'd8)
            frame_bit = byte_sel[3'(bit_idx - 4'd1)];
    end

    always_comb begin
        state_n    = state;
        phase_n    = phase_cnt;
        bit_cnt_n  = bit_cnt;
        bit_idx_n  = bit_idx;
        byte_idx_n = byte_idx;
        addr_n     = addr_q;
        done_n     = 1'b0;
        error_n    = 1'b0;
        busy_c     = 1'b1;
        power_c    = 1'b1;
        data_c     = 1'b1;
        apin_c     = 1'b0;
        case (state)
            IDLE: begin
                busy_c = 1'b0;
                apin_c = 1'b1;
                // outputs lag state by a cycle, so busy/done still high means the last run is finishing
                if (i_start_strobe && !o_busy && !o_done) begin
                    if (addr_ok) begin
                        addr_n  = i_address;
                        state_n = PWR_OFF;
                    end else begin
                        error_n = 1'b1;
                    end
                end
            end
            PWR_OFF: begin
                power_c = 1'b0;
                apin_c  = 1'b1;
                if (phase_cnt == PWR_LAST) begin
                    phase_n = '0;
                    state_n = SETTLE;
                end else begin
                    phase_n = phase_cnt + 24'd1;
                end
            end
            SETTLE: begin
                apin_c = 1'b1;
                if (phase_cnt == SET_LAST) begin
                    phase_n = '0;
                    state_n = ADDR_SETUP;
                end else begin
                    phase_n = phase_cnt + 24'd1;
                end
            end
            ADDR_SETUP: begin
                if (bit_end) begin
                    bit_cnt_n = '0;
                    state_n   = BREAK;
                end else begin
                    bit_cnt_n = bit_cnt + 1'b1;
                end
            end
            BREAK: begin
                data_c = 1'b0;
                if (phase_cnt == BRK_LAST) begin
                    phase_n = '0;
                    state_n = MAB;
                end else begin
                    phase_n = phase_cnt + 24'd1;
                end
            end
            MAB: begin
                if (phase_cnt == MAB_LAST) begin
                    phase_n    = '0;
                    bit_idx_n  = '0;
                    byte_idx_n = '0;
                    state_n    = BYTE;
                end else begin
                    phase_n = phase_cnt + 24'd1;
                end
            end
            BYTE: begin
                data_c = frame_bit;
                if (bit_end) begin
                    bit_cnt_n = '0;
                    if (bit_idx == 4'd10) begin
                        bit_idx_n = '0;
                        if (byte_idx == 2'd3) begin
                            byte_idx_n = '0;
                            state_n    = RELEASE;
                        end else begin
                            byte_idx_n = byte_idx + 2'd1;
                        end
                    end else begin
                        bit_idx_n = bit_idx + 4'd1;
                    end
                end else begin
                    bit_cnt_n = bit_cnt + 1'b1;
                end
            end
            RELEASE: begin
                if (bit_end) begin
                    bit_cnt_n = '0;
                    done_n    = 1'b1;
                    state_n   = IDLE;
                end else begin
                    bit_cnt_n = bit_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= IDLE;
            phase_cnt     <= '0;
            bit_cnt       <= '0;
            bit_idx       <= '0;
            byte_idx      <= '0;
            addr_q        <= '0;
            done_q        <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_error       <= 1'b0;
            o_power_en    <= 1'b1;
            o_data_pin    <= 1'b1;
            o_address_pin <= 1'b1;
        end else begin
            state         <= state_n;
            phase_cnt     <= phase_n;
            bit_cnt       <= bit_cnt_n;
            bit_idx       <= bit_idx_n;
            byte_idx      <= byte_idx_n;
            addr_q        <= addr_n;
            done_q        <= done_n;
            o_busy        <= busy_c;
            o_done        <= done_q;
            o_error       <= error_n;
            o_power_en    <= power_c;
            o_data_pin    <= data_c;
            o_address_pin <= apin_c;
        end
    end

endmodule

// File: tb/tb_ws2822_addr_programmer.sv
// Directed bench for ws2822_addr_programmer with shortened phase timing.
module tb_ws2822_addr_programmer;

    logic       clk = 1'b0;
    logic       i_rst;
    logic [9:0] i_address;
    logic       i_start_strobe;
    logic       o_busy, o_done, o_error, o_power_en, o_data_pin, o_address_pin;

    int total = 0;
    int bad   = 0;

    ws2822_addr_programmer #(
        .CLKS_PER_BIT(4), .POWER_OFF_CYCLES(16), .SETTLE_CYCLES(8),
        .BREAK_BITS(22), .MAB_BITS(2)
    ) dut (
        .i_clk(clk), .i_rst(i_rst), .i_address(i_address),
        .i_start_strobe(i_start_strobe), .o_busy(o_busy), .o_done(o_done),
        .o_error(o_error), .o_power_en(o_power_en), .o_data_pin(o_data_pin),
        .o_address_pin(o_address_pin)
    );

    always #5 clk = ~clk;

    // Strobes one run, records every busy cycle and decodes the frame from the recorded pin.
    task automatic run_capture(input logic [9:0] addr, input bit disturb,
                               output int busy_len, output int pwr_low, output int apin_low,
                               output int brk, output int mab, output int err_cnt,
                               output logic [31:0] bytes, output bit got_done,
                               output bit done_idle);
        logic q[$];
        int   i;
        busy_len = 0; pwr_low = 0; apin_low = 0; brk = 0; mab = 0; err_cnt = 0;
        got_done = 1'b0; done_idle = 1'b0; bytes = 'x;
        @(negedge clk);
        i_address = addr;
        i_start_strobe = 1'b1;
        @(negedge clk);
        i_start_strobe = 1'b0;
        for (int cyc = 0; cyc < 400 && !got_done; cyc++) begin
            @(negedge clk);
            if (o_busy) begin
                busy_len++;
                q.push_back(o_data_pin);
                if (!o_address_pin) apin_low++;
            end
            if (!o_power_en) pwr_low++;
            if (o_error) err_cnt++;
            if (o_done) begin
                got_done  = 1'b1;
                done_idle = !o_busy;
            end
            if (disturb) begin
                if (cyc == 5)   begin i_address = 10'd7; i_start_strobe = 1'b1; end
                if (cyc == 6)   i_start_strobe = 1'b0;
                if (cyc == 60)  i_address = 10'h3FF;
                if (cyc == 200) begin i_address = 10'd0; i_start_strobe = 1'b1; end
                if (cyc == 201) i_start_strobe = 1'b0;
            end
        end
        i = 0;
        while (i < q.size() && q[i] == 1'b1) i++;
        while (i < q.size() && q[i] == 1'b0) begin brk++; i++; end
        while (i < q.size() && q[i] == 1'b1) begin mab++; i++; end
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 8; k++) begin
                int idx;
                idx = i + b * 44 + (k + 1) * 4 + 2;
                bytes[b * 8 + k] = (idx < q.size()) ? q[idx] : 1'bx;
            end
        end
    endtask

    task automatic test_reset;
        i_rst = 1'b1; i_start_strobe = 1'b0; i_address = '0;
        repeat (2) @(negedge clk);
        total++;
        if ({o_busy, o_done, o_error, o_power_en, o_data_pin, o_address_pin} !== 6'b000111) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 000111",
                     {o_busy, o_done, o_error, o_power_en, o_data_pin, o_address_pin});
        end
        i_rst = 1'b0;
    endtask

    task automatic test_addr1;
        int bl, pl, al, br, mb, ec; logic [31:0] by; bit gd, di;
        run_capture(10'd1, 1'b0, bl, pl, al, br, mb, ec, by, gd, di);
        total++; if (bl !== 304) begin bad++; $display("FAIL a1_busy_len: got %0d want 304", bl); end
        total++; if (pl !== 16) begin bad++; $display("FAIL a1_power_low: got %0d want 16", pl); end
        total++; if (al !== 280) begin bad++; $display("FAIL a1_addr_pin_low: got %0d want 280", al); end
        total++; if (by !== 32'hF1F001A0) begin bad++; $display("FAIL a1_bytes: got %h want f1f001a0", by); end
        total++; if (gd !== 1'b1 || di !== 1'b1) begin bad++; $display("FAIL a1_done: seen=%0d idle_at_done=%0d want 1 1", gd, di); end
        total++; if (ec !== 0) begin bad++; $display("FAIL a1_error: got %0d want 0", ec); end
        @(negedge clk);
        total++;
        if ({o_done, o_busy, o_address_pin, o_power_en} !== 4'b0011) begin
            bad++; $display("FAIL a1_after_done: got %b want 0011", {o_done, o_busy, o_address_pin, o_power_en});
        end
    endtask

    task automatic test_break_mab;
        int bl, pl, al, br, mb, ec; logic [31:0] by; bit gd, di;
        run_capture(10'd1, 1'b0, bl, pl, al, br, mb, ec, by, gd, di);
        total++; if (br !== 88) begin bad++; $display("FAIL break_len: got %0d want 88", br); end
        total++; if (mb !== 8) begin bad++; $display("FAIL mab_len: got %0d want 8", mb); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_addr300_back_to_back;
        int bl, pl, al, br, mb, ec; logic [31:0] by; bit gd, di; int busy_seen;
        run_capture(10'd300, 1'b0, bl, pl, al, br, mb, ec, by, gd, di);
        total++; if (by !== 32'hDDF12CA0) begin bad++; $display("FAIL a300_bytes: got %h want ddf12ca0", by); end
        total++; if (bl !== 304) begin bad++; $display("FAIL a300_busy_len: got %0d want 304", bl); end
        // capture returns on the cycle o_done is high; strobe right now must be ignored
        i_address = 10'd5;
        i_start_strobe = 1'b1;
        @(negedge clk);
        i_start_strobe = 1'b0;
        busy_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (o_busy || !o_power_en || o_error) busy_seen++;
        end
        total++; if (busy_seen !== 0) begin bad++; $display("FAIL strobe_on_done: active cycles %0d want 0", busy_seen); end
    endtask

    task automatic test_addr512;
        int bl, pl, al, br, mb, ec; logic [31:0] by; bit gd, di;
        run_capture(10'd512, 1'b0, bl, pl, al, br, mb, ec, by, gd, di);
        total++; if (by !== 32'hF2F200A0) begin bad++; $display("FAIL a512_bytes: got %h want f2f200a0", by); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_errors;
        logic [9:0] bad_addr [2];
        int         active;
        bad_addr[0] = 10'd0;
        bad_addr[1] = 10'd513;
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            i_address = bad_addr[t];
            i_start_strobe = 1'b1;
            @(negedge clk);
            i_start_strobe = 1'b0;
            total++;
            if ({o_error, o_busy} !== 2'b10) begin
                bad++; $display("FAIL err_pulse_%0d: error,busy=%b want 10", bad_addr[t], {o_error, o_busy});
            end
            active = 0;
            repeat (5) begin
                @(negedge clk);
                if ({o_error, o_busy, o_done, o_power_en, o_data_pin, o_address_pin} !== 6'b000111) active++;
            end
            total++;
            if (active !== 0) begin bad++; $display("FAIL err_idle_%0d: non-idle cycles %0d want 0", bad_addr[t], active); end
        end
    endtask

    task automatic test_busy_disturb;
        int bl, pl, al, br, mb, ec; logic [31:0] by; bit gd, di;
        run_capture(10'd1, 1'b1, bl, pl, al, br, mb, ec, by, gd, di);
        total++; if (bl !== 304) begin bad++; $display("FAIL dist_busy_len: got %0d want 304", bl); end
        total++; if (by !== 32'hF1F001A0) begin bad++; $display("FAIL dist_bytes: got %h want f1f001a0", by); end
        total++; if (ec !== 0) begin bad++; $display("FAIL dist_error: got %0d want 0", ec); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int bl, pl, al, br, mb, ec; logic [31:0] by; bit gd, di; int dn;
        @(negedge clk);
        i_address = 10'd300;
        i_start_strobe = 1'b1;
        @(negedge clk);
        i_start_strobe = 1'b0;
        repeat (150) @(negedge clk);
        total++;
        if ({o_busy, o_address_pin} !== 2'b10) begin
            bad++; $display("FAIL mid_run_active: busy,addr_pin=%b want 10", {o_busy, o_address_pin});
        end
        i_rst = 1'b1;
        @(negedge clk);
        total++;
        if ({o_busy, o_done, o_error, o_power_en, o_data_pin, o_address_pin} !== 6'b000111) begin
            bad++;
            $display("FAIL mid_reset_outputs: got %b want 000111",
                     {o_busy, o_done, o_error, o_power_en, o_data_pin, o_address_pin});
        end
        i_rst = 1'b0;
        dn = 0;
        repeat (4) begin
            @(negedge clk);
            if (o_done || o_busy) dn++;
        end
        total++; if (dn !== 0) begin bad++; $display("FAIL mid_reset_quiet: active cycles %0d want 0", dn); end
        run_capture(10'd300, 1'b0, bl, pl, al, br, mb, ec, by, gd, di);
        total++; if (bl !== 304) begin bad++; $display("FAIL post_reset_busy: got %0d want 304", bl); end
        total++; if (by !== 32'hDDF12CA0) begin bad++; $display("FAIL post_reset_bytes: got %h want ddf12ca0", by); end
        total++; if (gd !== 1'b1) begin bad++; $display("FAIL post_reset_done: got %0d want 1", gd); end
    endtask

    initial begin
        test_reset;
        test_addr1;
        test_break_mab;
        test_addr300_back_to_back;
        test_addr512;
        test_errors;
        test_busy_disturb;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ws2822_addr_programmer.md
# ws2822_addr_programmer

Drives the WS2822 address-programming sequence on the strip's ADDRESS and DATA pins and switches strip power during it. It sits downstream of the configuration register block, in parallel with the DMX output path; the register block supplies the target start channel and a start strobe. The top level muxes its pin outputs onto DATA, ADDRESS and POWER_EN while programming mode is selected. One programming run covers one fixture: power-cycle, assert ADDRESS low, send one DMX-style address frame on DATA, then release.

## Interface
- CLKS_PER_BIT, 96: clock cycles per 4 µs bit (250 kbaud at 24 MHz)
- POWER_OFF_CYCLES, 2400000: cycles strip power is held off (100 ms)
- SETTLE_CYCLES, 1200000: cycles after power-on before ADDRESS asserts (50 ms)
- BREAK_BITS, 22: break length in bit times
- MAB_BITS, 2: mark-after-break length in bit times

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous, active-high reset
- i_address  in  10  target DMX start channel, valid 1..512, sampled on the accepted strobe
- i_start_strobe  in  1  one-cycle request to start a run
- o_busy  out  1  high from the cycle after an accepted strobe until o_done
- o_done  out  1  one-cycle pulse when a run completes
- o_error  out  1  one-cycle pulse when a strobe is rejected for an out-of-range address
- o_power_en  out  1  strip power enable
- o_data_pin  out  1  serial frame output, idle high (mark)
- o_address_pin  out  1  programming-enable output, idle high, low while programming

## Operation
- States: IDLE, PWR_OFF, SETTLE, ADDR_SETUP, BREAK, MAB, BYTE, RELEASE.
- IDLE:
  - A strobe with i_address in 1..512 latches the address and enters PWR_OFF.
  - A strobe with i_address 0 or >512 pulses o_error and stays in IDLE.
- PWR_OFF: o_power_en=0 for POWER_OFF_CYCLES, then SETTLE.
- SETTLE: o_power_en=1 for SETTLE_CYCLES, then ADDR_SETUP.
- ADDR_SETUP: o_address_pin=0 for 1 bit time. o_address_pin stays 0 through RELEASE.
- BREAK: o_data_pin=0 for BREAK_BITS×CLKS_PER_BIT cycles.
- MAB: o_data_pin=1 for MAB_BITS×CLKS_PER_BIT cycles.
- BYTE: 4 bytes are sent back to back, each 8N2 (start bit 0, data LSB first, two stop bits 1), 11 bit times per byte.
  - byte0 = 8'hA0
  - byte1 = addr[7:0]
  - byte2 = {6'b111100, addr[9:8]}
  - byte3 = byte1 ^ byte2
- RELEASE: o_data_pin=1 and o_address_pin=0 for 1 bit time. Then o_address_pin=1, o_done pulses, o_busy falls and the FSM returns to IDLE.
- Counters:
  - Bit timer counts 0..CLKS_PER_BIT-1.
  - Phase timer is 24 bits wide, enough for POWER_OFF_CYCLES.
  - Bit index 0..10; byte index 0..3.
- The latched address is held constant for the whole run; i_address changes during a run have no effect.

## Timing
- Reset values: o_busy=0, o_done=0, o_error=0, o_power_en=1, o_data_pin=1, o_address_pin=1; FSM in IDLE; all counters 0.
- Strobe accepted at edge n: o_busy=1 and o_power_en=0 after edge n+1.
- Every output is registered, and each phase lasts exactly its stated cycle count.
- Total busy time = POWER_OFF + SETTLE + CPB×(1 + BREAK_BITS + MAB_BITS + 44 + 1).
- o_done is high for exactly one cycle, in the cycle o_busy first reads 0.
- Strobes while o_busy=1 are ignored: no error pulse, no restart.
- A strobe arriving in the same cycle as o_done is ignored. A new run needs a strobe while IDLE.
- Reset asserted mid-run: all outputs return to reset values on the next edge, with no o_done. This includes o_power_en=1 and o_address_pin=1.
- o_error occurs 1 cycle after the rejected strobe.

## Test plan
Bench parameters: CLKS_PER_BIT=4, POWER_OFF_CYCLES=16, SETTLE_CYCLES=8, BREAK_BITS=22, MAB_BITS=2.

- Address 1 run:
  - Required: o_busy high for exactly 304 cycles; o_power_en low for 16 cycles.
  - Decoding o_data_pin must give bytes A0, 01, F0, F1, and o_done must pulse once.
- Address 300 (0x12C): decoded bytes A0, 2C, F1, DD.
- Address 0, then address 513: o_error pulses 1 cycle each time; o_busy stays 0 and all pins stay idle.
- Strobe re-issued while busy, and i_address changed mid-run: run length is still 304 cycles and bytes are unchanged.
- Reset during BYTE state: on the next edge o_power_en=1, o_data_pin=1, o_address_pin=1, o_busy=0, with no o_done. A following strobe produces a complete, correct run.
- Break and MAB width check: o_data_pin low for exactly 88 cycles, then high for exactly 8 cycles before byte0's start bit.
